// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC register, IF/ID pipeline register, fetch FSM
//
// Purpose:
//   Holds the program counter, presents it to instruction memory and captures the
//   returned word into the IF/ID register. Downstream stall holds the stage, a
//   redirect flushes it (one bubble) and refetches from the redirect target.
//   Optional feature macro: IF_EARLY_JUMP_EN (jump opcode 6'b000010 redirects the
//   PC in IF without waiting for downstream resolution).
//
// Ports:
//   clk            in   clock, all state on rising edge
//   reset          in   synchronous active-high reset
//   stall_i        in   ID cannot accept; hold PC and IF/ID
//   redirect_i     in   taken branch/jump from downstream; flush and refetch
//   redirect_pc_i  in   byte target for redirect_i (low two bits ignored)
//   imem_addr_o    out  byte fetch address (the PC register)
//   imem_rdata_i   in   instruction word read combinationally at imem_addr_o
//   ifid_valid_o   out  IF/ID holds a real instruction
//   ifid_instr_o   out  fetched instruction
//   ifid_pc_o      out  byte address of ifid_instr_o
//   ifid_pc4_o     out  ifid_pc_o + 4

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_pc4_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  seq_pc;

  // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 = 0.
  assign pc_plus4    = pc + 32'd4;
  assign imem_addr_o = pc;

`ifdef IF_EARLY_JUMP_EN
  logic        is_jump;
  logic [31:0] jump_off;

  // PC-relative word offset; the jump word itself still goes down the pipe.
  assign is_jump  = (imem_rdata_i[31:26] == 6'b000010);
  assign jump_off = {{4{imem_rdata_i[25]}}, imem_rdata_i[25:0], 2'b00};
  assign seq_pc   = is_jump ? (pc + jump_off) : pc_plus4;
`else
  assign seq_pc   = pc_plus4;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= {RESET_PC[31:2], 2'b00};
      state        <= RUN;
      ifid_valid_o <= 1'b0;
      ifid_instr_o <= 32'd0;
      ifid_pc_o    <= 32'd0;
      ifid_pc4_o   <= 32'd0;
    end else if (redirect_i) begin
      // Redirect wins over stall: the bubble replaces whatever IF/ID held.
      pc           <= {redirect_pc_i[31:2], 2'b00};
      state        <= FLUSH;
      ifid_valid_o <= 1'b0;
      ifid_instr_o <= 32'd0;
      ifid_pc_o    <= 32'd0;
      ifid_pc4_o   <= 32'd0;
    end else begin
      case (state)
        RUN:     if (stall_i) state <= HOLD;
        HOLD:    if (!stall_i) state <= RUN;
        FLUSH:   state <= stall_i ? HOLD : RUN;
        default: state <= RUN;
      endcase
      if (!stall_i) begin
        pc           <= {seq_pc[31:2], 2'b00};
        ifid_valid_o <= 1'b1;
        ifid_instr_o <= imem_rdata_i;
        ifid_pc_o    <= pc;
        ifid_pc4_o   <= pc_plus4;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized model-checked bench for if_stage

module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;

  logic [31:0] mem [0:63];

  int compared   = 0;
  int mismatched = 0;

  // reference state
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic [31:0] m_ipc4;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[7:2]];

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .imem_addr_o  (imem_addr),
    .imem_rdata_i (imem_rdata),
    .ifid_valid_o (ifid_valid),
    .ifid_instr_o (ifid_instr),
    .ifid_pc_o    (ifid_pc),
    .ifid_pc4_o   (ifid_pc4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Where the fetch after word w at address pc should go.
  function automatic logic [31:0] next_fetch(input logic [31:0] pc, input logic [31:0] w);
    logic [31:0] sx;
    sx = {{6{w[25]}}, w[25:0]};
`ifdef IF_EARLY_JUMP_EN
    if (w[31:26] == 6'b000010) return pc + sx * 32'd4;
`endif
    return pc + 32'd4;
  endfunction

  task automatic model_step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
    if (r) begin
      m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;
    end else if (rd) begin
      m_pc = rpc & 32'hFFFF_FFFC; m_valid = 1'b0; m_instr = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;
    end else if (!s) begin
      m_valid = 1'b1;
      m_instr = mem[m_pc[7:2]];
      m_ipc   = m_pc;
      m_ipc4  = m_pc + 32'd4;
      m_pc    = next_fetch(m_pc, m_instr);
    end
  endtask

  task automatic compare_all();
    chk("addr",  imem_addr, m_pc);
    chk("valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    chk("instr", ifid_instr, m_instr);
    chk("pc",    ifid_pc, m_ipc);
    chk("pc4",   ifid_pc4, m_ipc4);
  endtask

  task automatic cycle(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
    reset = r; stall = s; redirect = rd; redirect_pc = rpc;
    model_step(r, s, rd, rpc);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic run(); cycle(1'b0, 1'b0, 1'b0, 32'h0); endtask

  initial begin
    logic [31:0] w;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (w[31:26] == 6'b000010) w[31] = 1'b1;
      mem[i] = w;
    end
    mem[0] = 32'hAAAA_0001;
    mem[1] = 32'hBBBB_0002;
    mem[2] = 32'hCCCC_0003;
    mem[3] = 32'hDDDD_0004;
    mem[4] = {6'b000010, 26'd1};
    mem[16] = 32'h1234_5678;
    mem[63] = 32'h8765_4321;
    m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;

    // reset dominates stall and redirect
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0080);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_instr", ifid_instr, 32'h0);

    // sequential fetch A,B,C,D with a 3-cycle stall on B
    run();
    chk("A_instr", ifid_instr, 32'hAAAA_0001);
    chk("A_pc", ifid_pc, 32'h0);
    chk("A_valid", {31'd0, ifid_valid}, 32'd1);
    run();
    chk("B_instr", ifid_instr, 32'hBBBB_0002);
    chk("B_pc4", ifid_pc4, 32'h8);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      chk("stall_instr", ifid_instr, 32'hBBBB_0002);
      chk("stall_pc", ifid_pc, 32'h4);
      chk("stall_addr", imem_addr, 32'h8);
      chk("stall_valid", {31'd0, ifid_valid}, 32'd1);
    end
    run();
    chk("C_instr", ifid_instr, 32'hCCCC_0003);
    chk("C_pc", ifid_pc, 32'h8);
    run();
    chk("D_pc", ifid_pc, 32'hC);
    chk("D_addr", imem_addr, 32'h10);

    // jump word at pc 16, offset +1 word
    run();
    chk("J1_instr", ifid_instr, {6'b000010, 26'd1});
    chk("J1_pc", ifid_pc, 32'h10);
    chk("J1_addr", imem_addr, 32'h14);

    // jump word at pc 16, offset -1 word
    mem[4] = {6'b000010, 26'h3FF_FFFF};
    cycle(1'b0, 1'b0, 1'b1, 32'h10);
    run();
    chk("J2_valid", {31'd0, ifid_valid}, 32'd1);
`ifdef IF_EARLY_JUMP_EN
    chk("J2_addr", imem_addr, 32'hC);
`else
    chk("J2_addr", imem_addr, 32'h14);
`endif

    // redirect under stall, misaligned target
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0042);
    chk("RD_valid", {31'd0, ifid_valid}, 32'd0);
    chk("RD_addr", imem_addr, 32'h40);
    run();
    chk("RD_instr", ifid_instr, 32'h1234_5678);
    chk("RD_pc", ifid_pc, 32'h40);

    // wrap at top of address space
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    run();
    chk("W_instr", ifid_instr, 32'h8765_4321);
    chk("W_pc4", ifid_pc4, 32'h0);
    chk("W_addr", imem_addr, 32'h0);
    run();
    chk("W2_pc", ifid_pc, 32'h0);
    chk("W2_valid", {31'd0, ifid_valid}, 32'd1);

    // reset during HOLD with a valid instruction held
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("RH_valid", {31'd0, ifid_valid}, 32'd0);
    chk("RH_addr", imem_addr, 32'h0);
    chk("RH_pc", ifid_pc, 32'h0);
    chk("RH_pc4", ifid_pc4, 32'h0);
    run();
    chk("RH_first", ifid_instr, 32'hAAAA_0001);

    // randomized traffic, some jump words in memory
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if ($urandom_range(0, 7) == 0) w[31:26] = 6'b000010;
      mem[i] = w;
    end
    for (int n = 0; n < 600; n++) begin
      logic r, s, rd;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 49) == 0);
      s   = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 1) == 0) rpc[31:8] = '1;
      cycle(r, s, rd, rpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
